// File: rtl/count_step_decoder_pkg.sv
// Shared types and helpers for the count-bus step decoder.
package count_step_decoder_pkg;

  // Decoder states; the encoding is visible on the debug state output.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  // Classification of one accepted bus change relative to the reference.
  typedef enum logic [1:0] {
    DK_HOLD = 2'd0,
    DK_UP   = 2'd1,
    DK_DN   = 2'd2,
    DK_BAD  = 2'd3
  } delta_t;

  localparam int DELTA_UP = 1;

  // A down step is the all-ones delta of a w-bit bus (modular -1).
  function automatic delta_t classify_delta(input logic [31:0] d, input int w);
    logic [31:0] dn;
    dn = (32'd1 << w) - 32'd1;
    if (d == 32'd0)              return DK_HOLD;
    else if (d == 32'(DELTA_UP)) return DK_UP;
    else if (d == dn)            return DK_DN;
    else                         return DK_BAD;
  endfunction

endpackage

// File: rtl/count_step_decoder_if.sv
// Signal bundle between the count bus environment and the step decoder.
// Strobe semantics: there is no backpressure. The decoder samples count_in
// on every clk edge while enable=1; step is a one-cycle valid strobe whose
// companion outputs (dir_out, pos, period) are already updated in that cycle.
interface count_step_decoder_if #(
  parameter int DATA_WIDTH = 4,
  parameter int POS_WIDTH  = 16,
  parameter int PER_WIDTH  = 8
);
  import count_step_decoder_pkg::*;

  logic                  enable;
  logic                  clear;
  logic [DATA_WIDTH-1:0] count_in;
  logic                  step;
  logic                  dir_out;
  logic                  dir_valid;
  logic [POS_WIDTH-1:0]  pos;
  logic [PER_WIDTH-1:0]  period;
  logic                  period_valid;
  logic                  glitch_err;
  logic                  stalled;
  state_t                state_dbg;

  modport master (
    output enable, clear, count_in,
    input  step, dir_out, dir_valid, pos, period, period_valid,
           glitch_err, stalled, state_dbg
  );

  modport slave (
    input  enable, clear, count_in,
    output step, dir_out, dir_valid, pos, period, period_valid,
           glitch_err, stalled, state_dbg
  );
endinterface

// File: rtl/count_step_decoder_bus_stable_filter.sv
// Two-sample equality filter: a bus value is accepted once it has been seen
// on two consecutive edges; new_valid_o pulses when the accepted value changes
// (or on any stable value while rearm_i asks for a fresh reference).
module bus_stable_filter #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic                  rearm_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] value_o,
  output logic                  new_valid_o
);
  logic [DATA_WIDTH-1:0] samp_q, samp_d;
  logic [DATA_WIDTH-1:0] stable_q, stable_d;
  logic                  eq;

  assign eq          = (data_i == samp_q);
  assign value_o     = samp_q;
  assign new_valid_o = en_i && eq && (rearm_i || (data_i != stable_q));

  // Next sample / accepted value; everything holds while disabled.
  always_comb begin
    samp_d   = samp_q;
    stable_d = stable_q;
    if (en_i) begin
      samp_d = data_i;
      if (eq) stable_d = data_i;
    end
  end

  // Sample and accepted-value registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_q   <= '0;
      stable_q <= '0;
    end else begin
      samp_q   <= samp_d;
      stable_q <= stable_d;
    end
  end
endmodule

// File: rtl/count_step_decoder.sv
// Recovers motion from an up/down counter's count bus: step strobe, direction,
// signed position, inter-step period, illegal-jump and stall flags.
module count_step_decoder
  import count_step_decoder_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int POS_WIDTH  = 16,
  parameter int PER_WIDTH  = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  count_step_decoder_if.slave   bus
);
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] ref_q, ref_d;
  logic [PER_WIDTH-1:0]  cyc_q, cyc_d;
  logic [PER_WIDTH-1:0]  period_q, period_d;
  logic [POS_WIDTH-1:0]  pos_q, pos_d;
  logic step_q, step_d, dir_q, dir_d, dir_valid_q, dir_valid_d;
  logic period_valid_q, period_valid_d, glitch_q, glitch_d;
  logic stalled_q, stalled_d, have_prev_q, have_prev_d;

  logic [DATA_WIDTH-1:0] acc_value, delta;
  logic                  acc_new, rearm, moved, up, bad;
  logic [PER_WIDTH-1:0]  cyc_inc;
  delta_t                kind;

  assign rearm = (state_q == ST_IDLE);

  bus_stable_filter #(.DATA_WIDTH(DATA_WIDTH)) u_filter (
    .clk         (clk),
    .rst         (rst),
    .en_i        (bus.enable),
    .rearm_i     (rearm),
    .data_i      (bus.count_in),
    .value_o     (acc_value),
    .new_valid_o (acc_new)
  );

  assign delta   = acc_value - ref_q;
  assign kind    = classify_delta(32'(delta), DATA_WIDTH);
  assign moved   = acc_new && ((kind == DK_UP) || (kind == DK_DN));
  assign up      = (kind == DK_UP);
  assign bad     = acc_new && (kind == DK_BAD);
  assign cyc_inc = (&cyc_q) ? cyc_q : cyc_q + PER_WIDTH'(1);

  // FSM next state, delta actions, position and period bookkeeping.
  always_comb begin
    state_d        = state_q;
    ref_d          = ref_q;
    cyc_d          = cyc_q;
    period_d       = period_q;
    pos_d          = pos_q;
    step_d         = 1'b0;
    dir_d          = dir_q;
    dir_valid_d    = dir_valid_q;
    period_valid_d = period_valid_q;
    glitch_d       = glitch_q;
    stalled_d      = stalled_q;
    have_prev_d    = have_prev_q;

    if (!bus.enable) begin
      // Frozen; come back through IDLE so the bus is re-referenced.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (acc_new) begin
            ref_d       = acc_value;
            cyc_d       = '0;
            have_prev_d = 1'b0;
            stalled_d   = 1'b0;
            state_d     = ST_TRACK;
          end
        end
        ST_TRACK, ST_STALL: begin
          if (moved) begin
            step_d      = 1'b1;
            pos_d       = up ? pos_q + POS_WIDTH'(1) : pos_q - POS_WIDTH'(1);
            dir_d       = up;
            dir_valid_d = 1'b1;
            ref_d       = acc_value;
            cyc_d       = '0;
            // Only a step following a tracked step yields a period.
            if (state_q == ST_TRACK && have_prev_q) begin
              period_d       = cyc_inc;
              period_valid_d = 1'b1;
            end
            have_prev_d = 1'b1;
            stalled_d   = 1'b0;
            state_d     = ST_TRACK;
          end else begin
            if (bad) begin
              glitch_d = 1'b1;
              ref_d    = acc_value;
            end
            if (state_q == ST_TRACK) begin
              if (cyc_q == PER_WIDTH'(TIMEOUT - 1)) begin
                stalled_d = 1'b1;
                state_d   = ST_STALL;
              end else begin
                cyc_d = cyc_inc;
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Clear wins over any step decided above.
    if (bus.clear) begin
      pos_d          = '0;
      glitch_d       = 1'b0;
      period_valid_d = 1'b0;
      stalled_d      = 1'b0;
      step_d         = 1'b0;
      state_d        = ST_IDLE;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      ref_q          <= '0;
      cyc_q          <= '0;
      period_q       <= '0;
      pos_q          <= '0;
      step_q         <= 1'b0;
      dir_q          <= 1'b0;
      dir_valid_q    <= 1'b0;
      period_valid_q <= 1'b0;
      glitch_q       <= 1'b0;
      stalled_q      <= 1'b0;
      have_prev_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      ref_q          <= ref_d;
      cyc_q          <= cyc_d;
      period_q       <= period_d;
      pos_q          <= pos_d;
      step_q         <= step_d;
      dir_q          <= dir_d;
      dir_valid_q    <= dir_valid_d;
      period_valid_q <= period_valid_d;
      glitch_q       <= glitch_d;
      stalled_q      <= stalled_d;
      have_prev_q    <= have_prev_d;
    end
  end

  assign bus.step         = step_q;
  assign bus.dir_out      = dir_q;
  assign bus.dir_valid    = dir_valid_q;
  assign bus.pos          = pos_q;
  assign bus.period       = period_q;
  assign bus.period_valid = period_valid_q;
  assign bus.glitch_err   = glitch_q;
  assign bus.stalled      = stalled_q;
  assign bus.state_dbg    = state_q;
endmodule

// File: tb/tb_count_step_decoder.sv
// Bench for count_step_decoder: directed sequences, a vector table and a
// randomized walk against a timestamp-based reference model.
module tb_count_step_decoder;
  import count_step_decoder_pkg::*;

  localparam int DW = 4;
  localparam int PW = 16;
  localparam int RW = 8;
  localparam int TO = 64;
  localparam int OW = 30;

  logic clk = 1'b0;
  logic rst;

  count_step_decoder_if #(.DATA_WIDTH(DW), .POS_WIDTH(PW), .PER_WIDTH(RW)) bus ();

  count_step_decoder #(
    .DATA_WIDTH(DW), .POS_WIDTH(PW), .PER_WIDTH(RW), .TIMEOUT(TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [OW-1:0] exp_q[$];

  typedef struct {
    logic [DW-1:0] cin;
    logic          step;
    logic          dir;
    logic [PW-1:0] pos;
    logic          glitch;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [OW-1:0] outs();
    return {bus.step, bus.dir_out, bus.dir_valid, bus.pos, bus.period,
            bus.period_valid, bus.glitch_err, bus.stalled};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic [DW-1:0] v, input logic clr, input logic en);
    @(negedge clk);
    bus.count_in = v;
    bus.clear    = clr;
    bus.enable   = en;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.count_in = '0;
    bus.clear    = 1'b0;
    bus.enable   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic add_row(input int v, input bit s, input bit d, input int p, input bit g);
    vec_t r;
    r.cin = DW'(v); r.step = s; r.dir = d; r.pos = PW'(p); r.glitch = g;
    vecs.push_back(r);
  endtask

  task automatic add_step(input int v, input bit db, input int pb, input bit da, input int pa, input bit g);
    add_row(v, 1'b0, db, pb, g);
    add_row(v, 1'b1, da, pa, g);
    add_row(v, 1'b0, da, pa, g);
  endtask

  // ---------------- reference model ----------------
  // Works with edge timestamps: period and stall come from the distance
  // between the current edge and the last step / reference load.
  bit m_idle, m_stalled, m_dir, m_dv, m_pv, m_glitch, m_have_prev;
  int m_ref, m_pos, m_period, m_t, m_last, m_prev;

  task automatic model_reset();
    m_idle = 1; m_stalled = 0; m_dir = 0; m_dv = 0; m_pv = 0; m_glitch = 0;
    m_have_prev = 0; m_ref = 0; m_pos = 0; m_period = 0; m_t = 0; m_last = 0;
    m_prev = 0;
  endtask

  task automatic model_edge(input int c);
    bit acc, step;
    int d;
    step = 0;
    m_t++;
    acc = (c == m_prev);
    m_prev = c;
    d = (c - m_ref + 16) % 16;
    if (m_idle) begin
      if (acc) begin
        m_ref = c; m_idle = 0; m_last = m_t; m_have_prev = 0;
      end
    end else if (acc && (d == 1 || d == 15)) begin
      step  = 1;
      m_pos = (d == 1) ? (m_pos + 1) & 'hFFFF : (m_pos + 'hFFFF) & 'hFFFF;
      m_dir = (d == 1);
      m_dv  = 1;
      if (!m_stalled && m_have_prev) begin
        m_period = (m_t - m_last > 255) ? 255 : m_t - m_last;
        m_pv     = 1;
      end
      m_have_prev = 1; m_stalled = 0; m_last = m_t; m_ref = c;
    end else begin
      if (acc && d != 0) begin
        m_glitch = 1; m_ref = c;
      end
      if (!m_stalled && (m_t - m_last >= TO)) m_stalled = 1;
    end
    exp_q.push_back({step, m_dir, m_dv, PW'(m_pos), RW'(m_period), m_pv, m_glitch, m_stalled});
  endtask

  task automatic drive_model(input int v);
    logic [OW-1:0] e;
    cycle(DW'(v), 1'b0, 1'b1);
    model_edge(v);
    e = exp_q.pop_front();
    check("rand_outputs", 32'(outs()), 32'(e));
  endtask

  // ---------------- stimulus and checks ----------------
  initial begin
    int nst, since, cur, hold, kind, x;
    rst = 1'b1;
    do_reset();

    // Reset state.
    check("reset_outputs", 32'(outs()), 32'd0);
    check("reset_state", 32'(bus.state_dbg), 32'(ST_IDLE));

    // Up run 0..15,0 with 8-cycle spacing.
    cycle(4'd0, 1'b0, 1'b1);
    cycle(4'd0, 1'b0, 1'b1);
    nst = 0; since = 0;
    for (int v = 1; v <= 16; v++) begin
      for (int k = 0; k < 8; k++) begin
        cycle(DW'(v % 16), 1'b0, 1'b1);
        if (bus.step) begin
          if (nst == 0) check("up_first_pv", 32'(bus.period_valid), 32'd0);
          if (nst == 1) begin
            check("up_second_pv", 32'(bus.period_valid), 32'd1);
            check("up_second_period", 32'(bus.period), 32'd8);
          end
          nst++;
          since = 0;
        end else begin
          since++;
        end
      end
    end
    check("up_steps", 32'(nst), 32'd16);
    check("up_pos", 32'(bus.pos), 32'd16);
    check("up_dir", 32'({bus.dir_out, bus.dir_valid}), 32'b11);
    check("up_period", 32'({bus.period_valid, bus.period}), 32'h108);

    // Stall after TIMEOUT quiet cycles, then a step leaves it.
    for (int i = 0; i < 100; i++) begin
      if (bus.stalled) break;
      cycle(4'd0, 1'b0, 1'b1);
      since++;
    end
    check("stall_cycle", 32'(since), 32'(TO));
    check("stall_state", 32'(bus.state_dbg), 32'(ST_STALL));
    nst = 0;
    for (int k = 0; k < 8; k++) begin
      cycle(4'd1, 1'b0, 1'b1);
      if (bus.step) nst++;
    end
    check("unstall_step", 32'(nst), 32'd1);
    check("unstall_flag", 32'(bus.stalled), 32'd0);
    check("unstall_pos", 32'(bus.pos), 32'd17);
    check("unstall_period", 32'(bus.period), 32'd8);

    // Asynchronous reset mid-run.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_reset_outputs", 32'(outs()), 32'd0);
    bus.count_in = 4'd9;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    nst = 0;
    for (int k = 0; k < 6; k++) begin
      cycle(4'd9, 1'b0, 1'b1);
      if (bus.step) nst++;
    end
    check("post_reset_no_step", 32'(nst), 32'd0);
    check("post_reset_pos", 32'(bus.pos), 32'd0);
    for (int k = 0; k < 4; k++) begin
      cycle(4'd10, 1'b0, 1'b1);
      if (bus.step) nst++;
    end
    check("post_reset_step", 32'({nst[3:0], bus.pos}), 32'h10001);

    // Vector table: down wrap, up steps, spike, glitch.
    do_reset();
    for (int k = 0; k < 3; k++) cycle(4'd0, 1'b0, 1'b1);
    add_step(15, 0, 0,       0, 'hFFFF, 0);
    add_step(0,  0, 'hFFFF,  1, 0,      0);
    add_step(1,  1, 0,       1, 1,      0);
    add_step(2,  1, 1,       1, 2,      0);
    add_step(3,  1, 2,       1, 3,      0);
    add_row(7, 0, 1, 3, 0);
    for (int k = 0; k < 3; k++) add_row(3, 0, 1, 3, 0);
    add_row(5, 0, 1, 3, 0);
    add_row(5, 0, 1, 3, 1);
    add_row(5, 0, 1, 3, 1);
    add_step(6,  1, 3,       1, 4,      1);
    foreach (vecs[i]) begin
      cycle(vecs[i].cin, 1'b0, 1'b1);
      check($sformatf("vec%0d", i),
            32'({bus.step, bus.dir_out, bus.pos, bus.glitch_err}),
            32'({vecs[i].step, vecs[i].dir, vecs[i].pos, vecs[i].glitch}));
    end

    // Clear colliding with a step.
    cycle(4'd7, 1'b0, 1'b1);
    cycle(4'd7, 1'b1, 1'b1);
    check("clear_step", 32'(bus.step), 32'd0);
    check("clear_pos", 32'(bus.pos), 32'd0);
    check("clear_flags", 32'({bus.glitch_err, bus.period_valid}), 32'd0);
    check("clear_state", 32'(bus.state_dbg), 32'(ST_IDLE));
    cycle(4'd7, 1'b0, 1'b1);
    check("clear_reload", 32'({bus.step, bus.state_dbg}), 32'(ST_TRACK));
    nst = 0;
    for (int k = 0; k < 3; k++) begin
      cycle(4'd8, 1'b0, 1'b1);
      if (bus.step) nst++;
    end
    check("clear_next_step", 32'({nst[3:0], bus.pos}), 32'h10001);

    // Enable low freezes; re-enable re-references without a false glitch.
    nst = 0;
    for (int k = 0; k < 5; k++) begin
      cycle(4'd12, 1'b0, 1'b0);
      if (bus.step) nst++;
    end
    for (int k = 0; k < 5; k++) begin
      cycle(4'd12, 1'b0, 1'b1);
      if (bus.step) nst++;
    end
    check("enable_no_step", 32'(nst), 32'd0);
    check("enable_no_glitch", 32'({bus.glitch_err, bus.pos}), 32'h00001);
    for (int k = 0; k < 3; k++) begin
      cycle(4'd13, 1'b0, 1'b1);
      if (bus.step) nst++;
    end
    check("enable_next_step", 32'({nst[3:0], bus.pos}), 32'h10002);

    // Randomized walk against the reference model.
    do_reset();
    model_reset();
    cur = 0;
    for (int s = 0; s < 300; s++) begin
      kind = $urandom_range(0, 19);
      if (kind < 10) begin
        cur  = (cur + (($urandom_range(0, 1) == 1) ? 1 : 15)) % 16;
        hold = $urandom_range(2, 12);
      end else if (kind < 12) begin
        cur  = (cur + $urandom_range(2, 14)) % 16;
        hold = $urandom_range(2, 12);
      end else if (kind < 15) begin
        x = (cur + $urandom_range(1, 15)) % 16;
        drive_model(x);
        hold = $urandom_range(2, 6);
      end else if (kind < 19) begin
        hold = $urandom_range(2, 10);
      end else begin
        hold = $urandom_range(60, 80);
      end
      for (int h = 0; h < hold; h++) drive_model(cur);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
